apps_torque_gate: RTL and testbench

Downstream consumer of the ready-to-drive handshake. It sits between the pedal ADCs and the inverter command interface. It gates driver torque requests on ready_to_drive, and enforces the APPS dual-sensor implausibility and brake pedal plausibility (BPP) rules. It rate-limits torque rise and issues torque_cmd/inverter_enable to the motor controller link.

---
 rtl/apps_torque_gate.sv | 149 ++++++++++++++
 tb/tb_apps_torque_gate.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apps_torque_gate.sv
// APPS/BPP torque gate: samples pedal ADCs, checks plausibility and
// rate-limits the torque request sent to the inverter.
module apps_torque_gate #(
  parameter logic [11:0] BRAKE_THRESHOLD = 12'd2,
  parameter logic [11:0] APPS_DEV_MAX    = 12'd410,
  parameter logic [19:0] IMPLAUS_CYCLES  = 20'd100000,
  parameter logic [11:0] BPP_ENTER       = 12'd1024,
  parameter logic [11:0] BPP_EXIT        = 12'd205,
  parameter logic [11:0] RAMP_STEP       = 12'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready_to_drive,
  input  logic        sample_valid,
  input  logic [11:0] apps1,
  input  logic [11:0] apps2,
  input  logic [11:0] BSE,
  output logic [11:0] torque_cmd,
  output logic        torque_valid,
  output logic        inverter_enable,
  output logic        fault_apps,
  output logic        fault_bpp
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    BPP_CUT    = 2'd2,
    APPS_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] a1_q, a2_q, bse_q;
  logic        s1_q;
  logic [19:0] cnt_q, cnt_d;
  logic [11:0] tq_q, tq_d;
  logic        tv_q;
  logic        en_q, en_d;
  logic        fa_q, fa_d;
  logic        fb_q, fb_d;

  logic [12:0] sum;
  logic [11:0] avg;
  logic [11:0] dev;
  logic [12:0] up;
  logic [11:0] ramp;
  logic        implaus;
  logic        brake;

  assign sum     = {1'b0, a1_q} + {1'b0, a2_q};
  assign avg     = sum[12:1];
  assign dev     = (a1_q >= a2_q) ? (a1_q - a2_q) : (a2_q - a1_q);
  assign up      = {1'b0, tq_q} + {1'b0, RAMP_STEP};
  assign implaus = (cnt_q >= IMPLAUS_CYCLES);
  assign brake   = (bse_q > BRAKE_THRESHOLD);

  // 13-bit step sum: overflow past 4095 always exceeds avg, so min clamps.
  always_comb begin
    ramp = up[11:0];
    if (avg <= tq_q) begin
      ramp = avg;
    end else if (up >= {1'b0, avg}) begin
      ramp = avg;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (dev > APPS_DEV_MAX) begin
      cnt_d = implaus ? IMPLAUS_CYCLES : cnt_q + 20'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ready_to_drive) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!implaus && avg < BPP_EXIT) state_d = RUN;
        end
        RUN: begin
          if (implaus) state_d = APPS_FAULT;
          else if (brake && avg > BPP_ENTER) state_d = BPP_CUT;
        end
        BPP_CUT: begin
          if (implaus) state_d = APPS_FAULT;
          else if (avg < BPP_EXIT) state_d = RUN;
        end
        APPS_FAULT: state_d = APPS_FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tq_d = tq_q;
    if (!ready_to_drive || state_q != RUN) begin
      tq_d = '0;
    end else if (s1_q) begin
      tq_d = ramp;
    end
    en_d = (state_q == RUN) || (state_q == BPP_CUT);
    fa_d = (state_q == APPS_FAULT);
    fb_d = (state_q == BPP_CUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q  <= '0;
      a2_q  <= '0;
      bse_q <= '0;
    end else if (sample_valid) begin
      a1_q  <= apps1;
      a2_q  <= apps2;
      bse_q <= BSE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
      tq_q    <= '0;
      tv_q    <= 1'b0;
      en_q    <= 1'b0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= sample_valid;
      cnt_q   <= cnt_d;
      tq_q    <= tq_d;
      tv_q    <= s1_q;
      en_q    <= en_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign torque_cmd      = tq_q;
  assign torque_valid    = tv_q;
  assign inverter_enable = en_q;
  assign fault_apps      = fa_q;
  assign fault_bpp       = fb_q;

endmodule

// File: tb/tb_apps_torque_gate.sv
// Bench for apps_torque_gate: directed vector table, corner sequences,
// then randomized traffic against a cycle reference model.
module tb_apps_torque_gate;

  localparam int IC = 20;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_BPP  = 2;
  localparam int S_FLT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_to_drive;
  logic        sample_valid;
  logic [11:0] apps1;
  logic [11:0] apps2;
  logic [11:0] BSE;
  logic [11:0] torque_cmd;
  logic        torque_valid;
  logic        inverter_enable;
  logic        fault_apps;
  logic        fault_bpp;

  apps_torque_gate #(
    .IMPLAUS_CYCLES(20'd20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ready_to_drive (ready_to_drive),
    .sample_valid   (sample_valid),
    .apps1          (apps1),
    .apps2          (apps2),
    .BSE            (BSE),
    .torque_cmd     (torque_cmd),
    .torque_valid   (torque_valid),
    .inverter_enable(inverter_enable),
    .fault_apps     (fault_apps),
    .fault_bpp      (fault_bpp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model state
  int m_a1, m_a2, m_bse, m_cnt, m_st, m_tq;
  bit m_pend, m_tv, m_en, m_fa, m_fb;

  task automatic model_reset();
    m_a1 = 0; m_a2 = 0; m_bse = 0; m_cnt = 0; m_st = S_IDLE; m_tq = 0;
    m_pend = 0; m_tv = 0; m_en = 0; m_fa = 0; m_fb = 0;
  endtask

  task automatic model_step();
    int avg, dev, n_st, n_tq, n_cnt, lim;
    bit flt, rtd;
    rtd  = ready_to_drive;
    avg  = (m_a1 + m_a2) / 2;
    dev  = (m_a1 > m_a2) ? m_a1 - m_a2 : m_a2 - m_a1;
    flt  = (m_cnt == IC);
    n_cnt = (dev > 410) ? ((m_cnt < IC) ? m_cnt + 1 : IC) : 0;
    n_st = m_st;
    if (!rtd) n_st = S_IDLE;
    else if (m_st == S_IDLE) begin
      if (!flt && avg < 205) n_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (flt) n_st = S_FLT;
      else if (m_bse > 2 && avg > 1024) n_st = S_BPP;
    end else if (m_st == S_BPP) begin
      if (flt) n_st = S_FLT;
      else if (avg < 205) n_st = S_RUN;
    end
    n_tq = m_tq;
    if (!rtd || m_st != S_RUN) n_tq = 0;
    else if (m_pend) begin
      lim = m_tq + 16;
      if (lim > 4095) lim = 4095;
      n_tq = (avg <= m_tq) ? avg : ((lim < avg) ? lim : avg);
    end
    m_tv = m_pend;
    m_en = (m_st == S_RUN) || (m_st == S_BPP);
    m_fa = (m_st == S_FLT);
    m_fb = (m_st == S_BPP);
    m_tq = n_tq;
    m_st = n_st;
    m_cnt = n_cnt;
    if (sample_valid) begin
      m_a1 = apps1; m_a2 = apps2; m_bse = BSE;
    end
    m_pend = sample_valid;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rtd, input int a1, input int a2,
                       input int b, input bit sv);
    ready_to_drive = rtd;
    apps1 = 12'(a1);
    apps2 = 12'(a2);
    BSE = 12'(b);
    sample_valid = sv;
  endtask

  typedef struct {
    bit rtd;
    int a;
    int bse;
    int tq;
    bit en;
    bit fb;
  } vec_t;

  vec_t vt[17];
  bit   found;
  int   a, d, mode, rtd_p, lo, hi;

  initial begin
    vt[0]  = '{0, 2000, 0,   0,  0, 0};
    vt[1]  = '{1, 2000, 0,   0,  0, 0};
    vt[2]  = '{1, 100,  0,   0,  1, 0};
    vt[3]  = '{1, 40,   0,   16, 1, 0};
    vt[4]  = '{1, 40,   0,   32, 1, 0};
    vt[5]  = '{1, 40,   0,   40, 1, 0};
    vt[6]  = '{1, 40,   0,   40, 1, 0};
    vt[7]  = '{1, 40,   0,   40, 1, 0};
    vt[8]  = '{1, 2000, 0,   56, 1, 0};
    vt[9]  = '{1, 2000, 0,   72, 1, 0};
    vt[10] = '{1, 2000, 0,   88, 1, 0};
    vt[11] = '{1, 50,   0,   50, 1, 0};
    vt[12] = '{1, 1500, 100, 0,  1, 1};
    vt[13] = '{1, 1500, 0,   0,  1, 1};
    vt[14] = '{1, 200,  0,   0,  1, 0};
    vt[15] = '{1, 200,  0,   16, 1, 0};
    vt[16] = '{1, 200,  0,   32, 1, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tq", torque_cmd, 0);
    chk("reset_tv", torque_valid, 0);
    chk("reset_en", inverter_enable, 0);
    chk("reset_fa", fault_apps, 0);
    chk("reset_fb", fault_bpp, 0);
    rst = 1'b0;

    // table: one sample each, latency check then settled outputs
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rtd, vt[i].a, vt[i].a, vt[i].bse, 1);
      tick();
      sample_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_tv", i), torque_valid, 1);
      tick();
      tick();
      chk($sformatf("vec%0d_tq", i), torque_cmd, vt[i].tq);
      chk($sformatf("vec%0d_en", i), inverter_enable, vt[i].en);
      chk($sformatf("vec%0d_fb", i), fault_bpp, vt[i].fb);
    end

    // held deviation -> latched APPS fault, not before IC cycles
    drive(1, 1000, 1500, 0, 1);
    tick();
    sample_valid = 1'b0;
    repeat (19) tick();
    chk("implaus_early", fault_apps, 0);
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      tick();
      if (fault_apps) found = 1;
    end
    chk("implaus_fault_seen", found, 1);
    chk("implaus_en", inverter_enable, 0);
    chk("implaus_tq", torque_cmd, 0);

    drive(1, 100, 100, 0, 1);
    tick();
    sample_valid = 1'b0;
    repeat (30) tick();
    chk("fault_latched", fault_apps, 1);
    ready_to_drive = 1'b0;
    tick();
    tick();
    chk("fault_clear_fa", fault_apps, 0);
    chk("fault_clear_en", inverter_enable, 0);

    // deviation for only 19 cycles, then exact limit
    drive(1, 100, 100, 0, 1);
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    chk("rerun_en", inverter_enable, 1);
    drive(1, 1000, 1500, 0, 1);
    tick();
    sample_valid = 1'b0;
    repeat (18) tick();
    drive(1, 1000, 1000, 0, 1);
    tick();
    sample_valid = 1'b0;
    repeat (10) tick();
    chk("dev19_fa", fault_apps, 0);
    chk("dev19_en", inverter_enable, 1);
    drive(1, 1000, 1410, 0, 1);
    tick();
    sample_valid = 1'b0;
    repeat (40) tick();
    chk("dev410_fa", fault_apps, 0);
    chk("dev410_en", inverter_enable, 1);

    // ramp to 800 then async reset
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      drive(1, 800, 800, 0, 1);
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      if (torque_cmd == 12'd800) found = 1;
    end
    chk("ramp800_reached", found, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_tq", torque_cmd, 0);
    chk("async_rst_en", inverter_enable, 0);
    chk("async_rst_tv", torque_valid, 0);
    ready_to_drive = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_en", inverter_enable, 0);
    chk("post_rst_tq", torque_cmd, 0);

    // randomized traffic against the model
    mode = 0;
    rtd_p = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) begin
        mode = $urandom_range(0, 3);
        rtd_p = ($urandom_range(0, 4) != 0);
      end
      case (mode)
        0: begin a = $urandom_range(0, 250); d = $urandom_range(0, 300); end
        1: begin a = $urandom_range(900, 2500); d = $urandom_range(0, 200); end
        2: begin a = $urandom_range(300, 3000); d = $urandom_range(380, 700); end
        default: begin
          lo = $urandom_range(0, 5);
          a = (lo < 3) ? 204 + lo : 1020 + lo;
          d = 409 + $urandom_range(0, 2);
        end
      endcase
      hi = a + d / 2;
      if (hi > 4095) hi = 4095;
      lo = hi - d;
      if (lo < 0) lo = 0;
      if ($urandom_range(0, 1)) drive(1, hi, lo, 0, 0);
      else drive(1, lo, hi, 0, 0);
      ready_to_drive = rtd_p && ($urandom_range(0, 199) != 0);
      BSE = 12'($urandom_range(0, 3) == 0 ? $urandom_range(0, 4)
                                          : $urandom_range(0, 4095));
      sample_valid = (mode == 2) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 1) == 1);
      tick();
      chk("rnd_tq", torque_cmd, m_tq);
      chk("rnd_tv", torque_valid, m_tv);
      chk("rnd_en", inverter_enable, m_en);
      chk("rnd_fa", fault_apps, m_fa);
      chk("rnd_fb", fault_bpp, m_fb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
